// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM states, load funct3 encodings, memory source index.
package wb_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam int SRC_MEM = 0;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-writeback bundle: instruction handshake, memory response, flush and register-file write port.
interface wb_stage_if #(
  parameter int XLEN  = 32,
  parameter int NSRC  = 4,
  parameter int SEL_W = $clog2(NSRC)
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NSRC*XLEN-1:0] in_src;
  logic [SEL_W-1:0]     in_sel;
  logic [4:0]           in_rd;
  logic                 in_we;
  logic [2:0]           in_funct3;
  logic [2:0]           in_addr_lo;
  logic                 mem_rsp_valid;
  logic [XLEN-1:0]      mem_rsp_data;
  logic                 flush;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 busy;

  modport master (
    output in_valid, in_src, in_sel, in_rd, in_we, in_funct3, in_addr_lo,
    output mem_rsp_valid, mem_rsp_data, flush,
    input  in_ready, rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  in_valid, in_src, in_sel, in_rd, in_we, in_funct3, in_addr_lo,
    input  mem_rsp_valid, mem_rsp_data, flush,
    output in_ready, rf_we, rf_waddr, rf_wdata, busy
  );

endinterface

// File: rtl/wb_stage_load_ext.sv
// load_ext: combinational sub-word load extraction (byte/half/word lane select, sign or zero extend).
// Zero latency, no handshake; unused funct3 encodings pass the memory word through unchanged.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] result
);
  localparam int OFF_W = $clog2(XLEN / 8);

  logic [OFF_W-1:0] off;
  logic [XLEN-1:0]  shifted;
  logic             unused_addr;

  assign unused_addr = ^addr_lo;

  // Align the byte offset down to the access size so lanes never straddle.
  always_comb begin
    off = addr_lo[OFF_W-1:0];
    case (funct3)
      LH, LHU: off = off & ~OFF_W'(1);
      LW, LWU: off = off & ~OFF_W'(3);
      LD:      off = '0;
      default: ;
    endcase
  end

  assign shifted = data >> {off, 3'b000};

  always_comb begin
    result = data;
    case (funct3)
      LB:      result = XLEN'($signed(shifted[7:0]));
      LBU:     result = XLEN'(shifted[7:0]);
      LH:      result = XLEN'($signed(shifted[15:0]));
      LHU:     result = XLEN'(shifted[15:0]);
      LW:      result = XLEN'($signed(shifted[31:0]));
      LWU:     if (XLEN == 64) result = XLEN'(shifted[31:0]);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: source select + load wait, registered RF write (optional WB_LOAD_EXT_EN load extraction).
// rf_we one cycle after accept or after a waited response; in_ready low while a load waits, flush/reset abandon it.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NSRC  = 4,
  parameter int SEL_W = $clog2(NSRC)
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);
  wb_state_e       state, state_nxt;
  logic [4:0]      cap_rd;
  logic            cap_we;
  logic            accept, is_load, sel_ok, park;
  logic [XLEN-1:0] src_data, load_data;
  logic            commit, commit_we;
  logic [4:0]      commit_waddr;
  logic [XLEN-1:0] commit_wdata;
  logic            unused_src0;

  assign unused_src0  = ^bus.in_src[XLEN-1:0];
  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state == WAIT_MEM);
  assign accept       = bus.in_valid && (state == IDLE) && !bus.flush;
  assign is_load      = (bus.in_sel == SEL_W'(SRC_MEM));
  assign sel_ok       = (int'(bus.in_sel) < NSRC);
  assign park         = accept && is_load && !bus.mem_rsp_valid;

  always_comb begin
    src_data = '0;
    for (int i = 1; i < NSRC; i++)
      if (int'(bus.in_sel) == i) src_data = bus.in_src[i*XLEN +: XLEN];
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0] cap_funct3, cap_addr_lo, ext_funct3, ext_addr_lo;

  assign ext_funct3  = (state == WAIT_MEM) ? cap_funct3  : bus.in_funct3;
  assign ext_addr_lo = (state == WAIT_MEM) ? cap_addr_lo : bus.in_addr_lo;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .data    (bus.mem_rsp_data),
    .funct3  (ext_funct3),
    .addr_lo (ext_addr_lo),
    .result  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_funct3  <= '0;
      cap_addr_lo <= '0;
    end else if (park) begin
      cap_funct3  <= bus.in_funct3;
      cap_addr_lo <= bus.in_addr_lo;
    end
  end
`else
  logic unused_ext;

  assign unused_ext = ^{bus.in_funct3, bus.in_addr_lo};
  assign load_data  = bus.mem_rsp_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (park) state_nxt = WAIT_MEM;
      WAIT_MEM: if (bus.flush || bus.mem_rsp_valid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    commit       = 1'b0;
    commit_we    = 1'b0;
    commit_waddr = bus.in_rd;
    commit_wdata = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_load) begin
            commit       = bus.mem_rsp_valid;
            commit_we    = bus.in_we;
            commit_wdata = load_data;
          end else if (sel_ok) begin
            commit       = 1'b1;
            commit_we    = bus.in_we;
            commit_wdata = src_data;
          end else begin
            // Out-of-range select still lands rd with zero data, but never strobes.
            commit = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (!bus.flush && bus.mem_rsp_valid) begin
          commit       = 1'b1;
          commit_we    = cap_we;
          commit_waddr = cap_rd;
          commit_wdata = load_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_rd <= '0;
      cap_we <= 1'b0;
    end else if (park) begin
      cap_rd <= bus.in_rd;
      cap_we <= bus.in_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_we <= commit && commit_we && (commit_waddr != 5'd0);
      if (commit) begin
        bus.rf_waddr <= commit_waddr;
        bus.rf_wdata <= commit_wdata;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (XLEN=32, NSRC=3) with a transaction-level reference model checked every cycle.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int XLEN = 32;
  localparam int NSRC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(XLEN), .NSRC(NSRC)) bus ();
  wb_stage #(.XLEN(XLEN), .NSRC(NSRC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: at most one outstanding load; results follow the ISA load rules directly.
  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic [2:0] f3;
    logic [2:0] lo;
  } pend_t;

  pend_t       pend_q[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [2:0] f3, input logic [2:0] lo);
    logic [31:0] s;
    s = d;
`ifdef WB_LOAD_EXT_EN
    case (f3)
      3'b000, 3'b100: begin
        s = d >> (8 * (lo % 4));
        return (f3 == 3'b000 && s[7]) ? {24'hFF_FFFF, s[7:0]} : {24'h0, s[7:0]};
      end
      3'b001, 3'b101: begin
        s = d >> (16 * ((lo / 2) % 2));
        return (f3 == 3'b001 && s[15]) ? {16'hFFFF, s[15:0]} : {16'h0, s[15:0]};
      end
      default: return d;
    endcase
`else
    if (f3 == lo) s = d;
    return s;
`endif
  endfunction

  task automatic commit_m(input logic [4:0] rd, input logic we, input logic [31:0] d);
    m_waddr = rd;
    m_wdata = d;
    m_we    = we && (rd != 5'd0);
  endtask

  always @(posedge clk) begin
    pend_t p;
    m_we = 1'b0;
    if (rst) begin
      pend_q.delete();
      m_waddr = '0;
      m_wdata = '0;
    end else if (pend_q.size() != 0) begin
      if (bus.flush) pend_q.delete();
      else if (bus.mem_rsp_valid) begin
        p = pend_q.pop_front();
        commit_m(p.rd, p.we, extract(bus.mem_rsp_data, p.f3, p.lo));
      end
    end else if (bus.in_valid && !bus.flush) begin
      if (bus.in_sel == 0) begin
        if (bus.mem_rsp_valid)
          commit_m(bus.in_rd, bus.in_we, extract(bus.mem_rsp_data, bus.in_funct3, bus.in_addr_lo));
        else
          pend_q.push_back(pend_t'{bus.in_rd, bus.in_we, bus.in_funct3, bus.in_addr_lo});
      end else if (int'(bus.in_sel) < NSRC) begin
        commit_m(bus.in_rd, bus.in_we, 32'(bus.in_src >> (32 * bus.in_sel)));
      end else begin
        commit_m(bus.in_rd, 1'b0, 32'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model rf_we",    bus.rf_we,    m_we);
      chk("model rf_waddr", bus.rf_waddr, m_waddr);
      chk("model rf_wdata", bus.rf_wdata, m_wdata);
      chk("model in_ready", bus.in_ready, pend_q.size() == 0);
      chk("model busy",     bus.busy,     pend_q.size() != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.flush         = 1'b0;
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                       input logic [2:0] f3, input logic [2:0] lo);
    bus.in_valid   = 1'b1;
    bus.in_sel     = sel;
    bus.in_rd      = rd;
    bus.in_we      = we;
    bus.in_funct3  = f3;
    bus.in_addr_lo = lo;
  endtask

  task automatic rsp(input logic [31:0] d);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.in_src       = '0;
    bus.in_sel       = '0;
    bus.in_rd        = '0;
    bus.in_we        = 1'b0;
    bus.in_funct3    = '0;
    bus.in_addr_lo   = '0;
    bus.mem_rsp_data = '0;
    step();
    step();
    cmp_en = 1'b1;
    chk("reset in_ready", bus.in_ready, 1'b1);
    chk("reset busy",     bus.busy,     1'b0);
    chk("reset rf_we",    bus.rf_we,    1'b0);
    chk("reset rf_waddr", bus.rf_waddr, 5'd0);
    chk("reset rf_wdata", bus.rf_wdata, 32'h0);
    rst = 1'b0;

    // ALU writeback, then the strobe must drop.
    bus.in_src = {32'hCAFE_0004, 32'h0000_1234, 32'hDEAD_0000};
    issue(2'd1, 5'd5, 1'b1, LB, 3'd0);
    step();
    chk("alu rf_we",    bus.rf_we,    1'b1);
    chk("alu rf_waddr", bus.rf_waddr, 5'd5);
    chk("alu rf_wdata", bus.rf_wdata, 32'h0000_1234);
    idle();
    step();
    chk("alu pulse end", bus.rf_we,    1'b0);
    chk("alu hold data", bus.rf_wdata, 32'h0000_1234);

    // rd=0 suppresses the strobe.
    issue(2'd2, 5'd0, 1'b1, LB, 3'd0);
    step();
    chk("rd0 rf_we", bus.rf_we, 1'b0);

    // Back-to-back commits.
    bus.in_src = {32'h0000_2222, 32'h0000_1111, 32'hDEAD_0000};
    issue(2'd1, 5'd7, 1'b1, LB, 3'd0);
    step();
    chk("b2b0 rf_wdata", bus.rf_wdata, 32'h0000_1111);
    issue(2'd2, 5'd8, 1'b1, LB, 3'd0);
    step();
    chk("b2b1 rf_we",    bus.rf_we,    1'b1);
    chk("b2b1 rf_waddr", bus.rf_waddr, 5'd8);
    chk("b2b1 rf_wdata", bus.rf_wdata, 32'h0000_2222);
    idle();

    // Delayed LB, byte lane 3, response three cycles after accept.
    issue(2'd0, 5'd10, 1'b1, LB, 3'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      idle();
      chk("wait in_ready", bus.in_ready, 1'b0);
      chk("wait busy",     bus.busy,     1'b1);
      chk("wait rf_we",    bus.rf_we,    1'b0);
    end
    rsp(32'h80FF_FFFF);
    step();
    idle();
    chk("lb rf_we",    bus.rf_we,    1'b1);
    chk("lb rf_waddr", bus.rf_waddr, 5'd10);
`ifdef WB_LOAD_EXT_EN
    chk("lb rf_wdata", bus.rf_wdata, 32'hFFFF_FF80);
`else
    chk("lb rf_wdata", bus.rf_wdata, 32'h80FF_FFFF);
`endif
    chk("lb in_ready", bus.in_ready, 1'b1);
    step();
    chk("lb pulse end", bus.rf_we, 1'b0);

    // Loads with same-cycle data: LH upper half, LBU lane 1, LW.
    issue(2'd0, 5'd11, 1'b1, LH, 3'd2);
    rsp(32'h8001_7FFF);
    step();
`ifdef WB_LOAD_EXT_EN
    chk("lh rf_wdata", bus.rf_wdata, 32'hFFFF_8001);
`else
    chk("lh rf_wdata", bus.rf_wdata, 32'h8001_7FFF);
`endif
    issue(2'd0, 5'd12, 1'b1, LBU, 3'd1);
    rsp(32'h0000_A500);
    step();
`ifdef WB_LOAD_EXT_EN
    chk("lbu rf_wdata", bus.rf_wdata, 32'h0000_00A5);
`else
    chk("lbu rf_wdata", bus.rf_wdata, 32'h0000_A500);
`endif
    issue(2'd0, 5'd13, 1'b1, LW, 3'd4);
    rsp(32'h1234_5678);
    step();
    chk("lw rf_wdata", bus.rf_wdata, 32'h1234_5678);
    chk("lw rf_we",    bus.rf_we,    1'b1);
    idle();

    // Flush while waiting, with a colliding response, then a stray response.
    issue(2'd0, 5'd14, 1'b1, LB, 3'd0);
    step();
    idle();
    chk("flush pre busy", bus.busy, 1'b1);
    bus.flush = 1'b1;
    rsp(32'h0000_0055);
    step();
    idle();
    chk("flush in_ready", bus.in_ready, 1'b1);
    chk("flush busy",     bus.busy,     1'b0);
    chk("flush rf_we",    bus.rf_we,    1'b0);
    rsp(32'h0000_0066);
    step();
    idle();
    chk("stray rf_we",    bus.rf_we,    1'b0);
    chk("stray rf_waddr", bus.rf_waddr, 5'd13);

    // Flush beats a simultaneous instruction.
    issue(2'd1, 5'd15, 1'b1, LB, 3'd0);
    bus.flush = 1'b1;
    step();
    idle();
    chk("flush idle rf_we",    bus.rf_we,    1'b0);
    chk("flush idle rf_waddr", bus.rf_waddr, 5'd13);

    // Out-of-range select on NSRC=3.
    issue(2'd3, 5'd16, 1'b1, LB, 3'd0);
    step();
    idle();
    chk("oor rf_we",    bus.rf_we,    1'b0);
    chk("oor rf_wdata", bus.rf_wdata, 32'h0);

    // Reset in the middle of a wait.
    issue(2'd0, 5'd17, 1'b1, LB, 3'd0);
    step();
    idle();
    chk("rstw pre busy", bus.busy, 1'b1);
    rst = 1'b1;
    step();
    chk("rstw in_ready", bus.in_ready, 1'b1);
    chk("rstw busy",     bus.busy,     1'b0);
    chk("rstw rf_we",    bus.rf_we,    1'b0);
    chk("rstw rf_waddr", bus.rf_waddr, 5'd0);
    chk("rstw rf_wdata", bus.rf_wdata, 32'h0);
    rst = 1'b0;
    step();
    step();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised writeback stage for the RISC-V pipeline, sitting between the MEM stage and the register file write port. It selects one of NSRC result sources and waits on a variable-latency memory response for loads. It also performs sub-word load extraction with sign or zero extension, and registers the final register-file write (enable, address, data). It replaces the purely combinational writeback select with a handshaked, stallable and flushable stage.

## Interface

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- NSRC, 4: number of writeback sources; source 0 is always memory load data. Default mapping: 1 = ALU, 2 = PC+4, 3 = CSR/imm.
- SEL_W, $clog2(NSRC): width of the source select.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; equals (state == IDLE).
- in_src  in  NSRC*XLEN  packed non-memory sources; slice i = in_src[i*XLEN +: XLEN]; slice 0 is unused.
- in_sel  in  SEL_W  writeback source select.
- in_rd  in  5  destination register.
- in_we  in  1  instruction writes rd.
- in_funct3  in  3  load size/sign encoding.
- in_addr_lo  in  3  low bits of the load address.
- mem_rsp_valid  in  1  load data valid this cycle.
- mem_rsp_data  in  XLEN  raw aligned memory word.
- flush  in  1  kill the pending or accepted instruction.
- rf_we  out  1  register-file write strobe; a one-cycle pulse.
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- busy  out  1  high in WAIT_MEM.

## Operation

- States: IDLE, WAIT_MEM.
- **Accept:** an instruction is accepted when in_valid && in_ready && !flush.
- **Non-load accept in IDLE** (in_sel != 0):
  - Register rf_wdata = in_src[in_sel] and rf_waddr = in_rd.
  - rf_we = in_we && (in_rd != 0).
  - Stay in IDLE.
- **Load accept with data** (in_sel == 0 and mem_rsp_valid in the same cycle): commit exactly as for a non-load, using the extracted load data.
- **Load accept without data** (in_sel == 0, mem_rsp_valid low):
  - Capture rd, we, funct3 and addr_lo.
  - Go to WAIT_MEM; in_ready drops.
- **WAIT_MEM:** on mem_rsp_valid, commit the extracted data with the captured rd/we and return to IDLE. Otherwise hold.
- **Out-of-range select** (in_sel >= NSRC): rf_wdata = 0 and rf_we = 0. No X is ever driven.
- **Idle cycles:** rf_we = 0 in every cycle without a commit. rf_waddr and rf_wdata hold their last value.
- **Stray response:** mem_rsp_valid in IDLE with no load being accepted is ignored.
- **Flush:**
  - Forces the next-cycle rf_we = 0 and sends WAIT_MEM to IDLE, discarding captured state.
  - A simultaneous in_valid is discarded (flush wins).
  - A simultaneous mem_rsp_valid is discarded.
- **Reset:** takes priority over flush. State = IDLE, rf_we = 0, rf_waddr = 0, rf_wdata = 0, busy = 0. Any wait in progress is abandoned.

## Timing

- Latency: rf_we rises in the cycle after acceptance (non-load, or load with same-cycle data). For a waiting load, it rises in the cycle after mem_rsp_valid.
- Throughput: one commit per cycle when no load waits.
- Combinational paths:
  - in_ready depends only on state, not on in_valid.
  - There is no combinational path from mem_rsp_data to any output.
- Every commit is a single-cycle rf_we pulse.

## Configuration

- Macro: WB_LOAD_EXT_EN.
- **Defined:** memory data passes through load extraction on in_funct3:
  - 000 LB and 100 LBU: byte lane addr_lo.
  - 001 LH and 101 LHU: halfword lane addr_lo[2:1].
  - 010 LW: sign-extended 32-bit word lane addr_lo[2].
  - 110 LWU: zero-extended (XLEN=64 only).
  - 011 LD: full word.
  - Signed forms sign-extend to XLEN. Unused encodings pass mem_rsp_data unchanged.
- **Undefined:** mem_rsp_data is written unmodified; in_funct3 and in_addr_lo are ignored and not captured.

## Structure

- Package wb_pkg holds:
  - the state enum (IDLE, WAIT_MEM);
  - the load funct3 constants (LB, LH, LW, LD, LBU, LHU, LWU);
  - the localparam SRC_MEM = 0.
- Sub-module load_ext: combinational extraction; inputs data, funct3 and addr_lo; output XLEN data. It is instantiated only under WB_LOAD_EXT_EN.

## Test plan

- **ALU writeback:** in_sel=1, in_src[1]=32'h0000_1234, rd=5, we=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=32'h0000_1234; the cycle after, rf_we=0.
- **rd=0 suppression:** in_sel=2, rd=0, we=1 → rf_we stays 0.
- **Delayed load with sign extension:** LB, addr_lo=3, rsp arrives 3 cycles later with 32'h80FF_FFFF → in_ready=0 and busy=1 for 3 cycles; the cycle after the response, rf_wdata=32'hFFFF_FF80.
  - With WB_LOAD_EXT_EN undefined, the same stimulus gives rf_wdata=32'h80FF_FFFF.
- **Flush in WAIT_MEM:** flush while waiting → state returns to IDLE. A mem_rsp_valid arriving afterwards produces no rf_we.
- **Out-of-range select:** NSRC=3, in_sel=3 → rf_we=0, rf_wdata=0.
- **Reset mid-wait:** rst asserted in WAIT_MEM → next cycle in_ready=1, busy=0, rf_we=0, rf_waddr=0, rf_wdata=0.
